// File: rtl/uni_shift_nbit_seq.sv
// Sequential universal shift register: multi-step shift/rotate/load driven by a start strobe.
// Define UNI_SHIFT_ROTATE_EN to enable the ROR, ROL and ASR modes (otherwise they behave as hold).
module uni_shift_nbit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in_L,
  input  logic             serial_in_R,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_L,
  output logic             serial_out_R,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
`ifdef UNI_SHIFT_ROTATE_EN
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             step_mode_c;
  logic [WIDTH-1:0] step_c;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Modes that need at least one step cycle; everything else finishes straight from IDLE.
  always_comb begin
    step_mode_c = 1'b0;
    case (mode)
      MODE_SHR, MODE_SHL: step_mode_c = 1'b1;
`ifdef UNI_SHIFT_ROTATE_EN
      MODE_ROR, MODE_ROL, MODE_ASR: step_mode_c = 1'b1;
`endif
      default: step_mode_c = 1'b0;
    endcase
  end

  // One step of the latched mode; serial fills are taken live at the step edge.
  always_comb begin
    step_c = q_q;
    case (mode_q)
      MODE_SHR: step_c = {serial_in_L, q_q[WIDTH-1:1]};
      MODE_SHL: step_c = {q_q[WIDTH-2:0], serial_in_R};
`ifdef UNI_SHIFT_ROTATE_EN
      MODE_ROR: step_c = {q_q[0], q_q[WIDTH-1:1]};
      MODE_ROL: step_c = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ASR: step_c = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
`endif
      default:  step_c = q_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = amount;
          if (mode == MODE_LOAD) begin
            q_d     = parallel_in;
            state_d = ST_DONE;
          end else if (!step_mode_c || (amount == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        q_d   = step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign q            = q_q;
  assign serial_out_L = q_q[WIDTH-1];
  assign serial_out_R = q_q[0];
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_uni_shift_nbit_seq.sv
// Self-checking bench for uni_shift_nbit_seq (WIDTH=8, CNT_W=4): directed table, corner sequences, random ops.
module tb_uni_shift_nbit_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             serial_in_L;
  logic             serial_in_R;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] q;
  logic             serial_out_L;
  logic             serial_out_R;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q = 8'h00;

  uni_shift_nbit_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amount(amount),
    .serial_in_L(serial_in_L), .serial_in_R(serial_in_R), .parallel_in(parallel_in),
    .q(q), .serial_out_L(serial_out_L), .serial_out_R(serial_out_R),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] pin;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Modes that complete without stepping.
  function automatic bit is_noop(input logic [2:0] m);
`ifdef UNI_SHIFT_ROTATE_EN
    return (m == 3'd0) || (m == 3'd7);
`else
    return (m == 3'd0) || (m >= 3'd4);
`endif
  endfunction

  // Reference step computed arithmetically from the mode definitions.
  function automatic logic [7:0] ref_step(input logic [2:0] m, input logic [7:0] v,
                                          input logic sl, input logic sr);
    int x;
    x = int'(v);
    case (m)
      3'd1: x = (x / 2) + (sl ? 128 : 0);
      3'd2: x = ((x * 2) % 256) + (sr ? 1 : 0);
      3'd4: x = (x / 2) + ((x % 2) * 128);
      3'd5: x = ((x * 2) % 256) + (x / 128);
      3'd6: x = (x / 2) + ((x >= 128) ? 128 : 0);
      default: x = x;
    endcase
    return 8'(x);
  endfunction

  // sel: 0/1 fixed serial value, 2 random per step.
  task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] pin,
                        input int sl_sel, input int sr_sel, input bit junk);
    int n;
    logic sl_v, sr_v;
    start = 1'b1; mode = m; amount = a; parallel_in = pin;
    if (m == 3'd3) begin
      model_q = pin;
      n = 0;
    end else if (is_noop(m) || a == 4'd0) begin
      n = 0;
    end else begin
      n = int'(a);
    end
    tick();
    start = 1'b0;
    chk("e0_busy", 8'(busy), 8'd1);
    chk("e0_done", 8'(done), 8'(n == 0));
    chk("e0_q", q, model_q);
    for (int k = 1; k <= n; k++) begin
      sl_v = (sl_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(sl_sel);
      sr_v = (sr_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(sr_sel);
      serial_in_L = sl_v; serial_in_R = sr_v;
      if (junk) begin
        start = 1'($urandom_range(0, 1)); mode = 3'($urandom);
        amount = 4'($urandom); parallel_in = 8'($urandom);
      end
      tick();
      model_q = ref_step(m, model_q, sl_v, sr_v);
      chk("step_q", q, model_q);
      chk("step_sol", 8'(serial_out_L), 8'(model_q[7]));
      chk("step_sor", 8'(serial_out_R), 8'(model_q[0]));
      chk("step_busy", 8'(busy), 8'd1);
      chk("step_done", 8'(done), 8'(k == n));
    end
    if (junk) begin
      start = 1'($urandom_range(0, 1)); mode = 3'($urandom); amount = 4'($urandom);
    end
    tick();
    start = 1'b0;
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_done", 8'(done), 8'd0);
    chk("idle_q", q, model_q);
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; amount = 4'd0;
    serial_in_L = 1'b0; serial_in_R = 1'b0; parallel_in = 8'h00;

    // Directed table, applied back to back from reset (q starts at 0).
    vecs.push_back('{3'd3, 4'd0,  8'hAA, 1'b0, 1'b0, 8'hAA});
    vecs.push_back('{3'd1, 4'd3,  8'h00, 1'b1, 1'b0, 8'hF5});
    vecs.push_back('{3'd3, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81});
`ifdef UNI_SHIFT_ROTATE_EN
    vecs.push_back('{3'd5, 4'd10, 8'h00, 1'b0, 1'b0, 8'h06});
`else
    vecs.push_back('{3'd5, 4'd10, 8'h00, 1'b0, 1'b0, 8'h81});
`endif
    vecs.push_back('{3'd3, 4'd0,  8'h90, 1'b0, 1'b0, 8'h90});
`ifdef UNI_SHIFT_ROTATE_EN
    vecs.push_back('{3'd6, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE4});
`else
    vecs.push_back('{3'd6, 4'd2,  8'h00, 1'b0, 1'b0, 8'h90});
`endif
    vecs.push_back('{3'd3, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C});
`ifdef UNI_SHIFT_ROTATE_EN
    vecs.push_back('{3'd4, 4'd4,  8'h00, 1'b0, 1'b0, 8'hC3});
    vecs.push_back('{3'd4, 4'd4,  8'h00, 1'b0, 1'b0, 8'h3C});
`else
    vecs.push_back('{3'd4, 4'd4,  8'h00, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{3'd4, 4'd4,  8'h00, 1'b0, 1'b0, 8'h3C});
`endif
    vecs.push_back('{3'd2, 4'd0,  8'h00, 1'b0, 1'b1, 8'h3C});
    vecs.push_back('{3'd2, 4'd12, 8'h00, 1'b0, 1'b1, 8'hFF});
    vecs.push_back('{3'd1, 4'd9,  8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{3'd3, 4'd0,  8'h5A, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{3'd0, 4'd5,  8'hFF, 1'b1, 1'b1, 8'h5A});
    vecs.push_back('{3'd7, 4'd5,  8'hFF, 1'b1, 1'b1, 8'h5A});

    tick(); tick();
    chk("rst_q", q, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_sol", 8'(serial_out_L), 8'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; mode = 3'd3; parallel_in = 8'hC7;
    tick();
    start = 1'b0;
    chk("rstprio_q", q, 8'h00);
    chk("rstprio_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].pin, int'(vecs[i].sl), int'(vecs[i].sr), 1'b1);
      chk($sformatf("vec%0d_final", i), q, vecs[i].exp_q);
    end

    // Reset in the middle of a shift aborts without a done pulse.
    run_op(3'd3, 4'd0, 8'hFF, 0, 0, 1'b0);
    start = 1'b1; mode = 3'd2; amount = 4'd5; serial_in_R = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("abort_e1_q", q, 8'hFE);
    rst_n = 1'b0;
    tick();
    chk("abort_q", q, 8'h00);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_done2", 8'(done), 8'd0);
    chk("abort_busy2", 8'(busy), 8'd0);
    model_q = 8'h00;

    // Random operations with random serial fills and junk on the command inputs while busy.
    for (int r = 0; r < 60; r++) begin
      run_op(3'($urandom), 4'($urandom), 8'($urandom), 2, 2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uni_shift_nbit_seq.md
UNI_SHIFT_NBIT_SEQ -- requirements
Module: uni_shift_nbit_seq

Interface
REQ-001 Parameter WIDTH, default 8: register width, at least 2.
REQ-002 Parameter CNT_W, default 4: width of the amount port; SHALL be at least clog2(WIDTH+1).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  command strobe, sampled only in IDLE.
REQ-006 mode  input  3  operation select, sampled with start.
REQ-007 amount  input  CNT_W  number of shift steps, sampled with start.
REQ-008 serial_in_L  input  1  fill bit entering at the MSB end.
REQ-009 serial_in_R  input  1  fill bit entering at the LSB end.
REQ-010 parallel_in  input  WIDTH  load data.
REQ-011 q  output  WIDTH  register contents.
REQ-012 serial_out_L  output  1  equals q[WIDTH-1].
REQ-013 serial_out_R  output  1  equals q[0].
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 Modes: 000 hold; 001 SHR (q <= {serial_in_L, q[W-1:1]}); 010 SHL (q <= {q[W-2:0], serial_in_R}); 011 LOAD; 100 ROR; 101 ROL; 110 ASR (MSB replicated); 111 reserved, treated as hold.
REQ-017 FSM states: IDLE, SHIFT, DONE.
REQ-018 IDLE with start=1 at edge E0: mode and amount SHALL be latched.
REQ-019 From IDLE on start, next state SHALL be:
- DONE with q <= parallel_in, if LOAD.
- DONE with q unchanged, if hold, reserved or amount==0.
- Otherwise SHIFT with the step counter set to amount.
REQ-020 SHIFT: each edge SHALL apply exactly one step of the latched mode and decrement the counter; the step that brings the counter to 0 SHALL move the state to DONE.
REQ-021 Latency: shift by N SHALL update q at edges E1..EN; done SHALL be high for the one cycle following EN; LOAD/no-op done SHALL be high for the cycle following E0.
REQ-022 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-023 start SHALL be ignored while busy=1; mode and amount changes mid-operation SHALL have no effect.
REQ-024 Serial inputs SHALL be sampled live at each step edge, not latched at start.
REQ-025 amount > WIDTH SHALL execute all amount steps; rotates wrap modulo WIDTH; SHR/SHL/ASR saturate to fill pattern.
REQ-026 serial_out_L/R SHALL be combinational from q.

Reset
REQ-027 rst_n=0 at an edge SHALL force q=0, state IDLE, counter=0, busy=0, done=0; reset SHALL take priority over start and any in-progress operation.
REQ-028 Reset mid-SHIFT SHALL abort with no done pulse.

Configuration
REQ-029 Macro UNI_SHIFT_ROTATE_EN defined: modes 100, 101 and 110 SHALL operate as in REQ-016.
REQ-030 Macro undefined: modes 100, 101 and 110 SHALL behave as hold (DONE next cycle, q unchanged) and rotate/ASR logic SHALL be absent.

Verification (WIDTH=8, CNT_W=4)
REQ-031 Reset, then start mode=011 with parallel_in=0xAA -> q=0xAA after E0; busy and done high for one cycle.
REQ-032 From 0xAA, start mode=001 with amount=3 and serial_in_L=1 -> q=0xD5, 0xEA, 0xF5 at E1..E3; done in the following cycle.
REQ-033 Macro on, from 0x81, mode=101 with amount=10 -> q=0x06 after E10; done in the cycle following E10; start pulses during busy ignored.
REQ-034 Macro on, from 0x90, mode=110 with amount=2 -> q=0xE4.
REQ-035 From 0xFF, mode=010 with amount=5 and serial_in_R=0; rst_n=0 at E2 -> q=0x00, busy=0, no done pulse.
REQ-036 Macro off, from 0x3C, mode=100 with amount=4 -> q stays 0x3C; done pulses one cycle after E0.
